// File: rtl/pipe_slot_sched_if.sv
// Bus bundle for pipe_slot_sched: decode issue handshake, stall/kill controls,
// per-slot write-back data in, and slot status / retire information out.
// The master side is the surrounding pipeline control; the slave side is the scheduler.
interface pipe_slot_sched_if #(
    parameter int NUM_SLOTS = 3,
    parameter int STAGE_W   = 3,
    parameter int DATA_W    = 32
);
    localparam int SLOT_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;

    logic                           issue_valid;
    logic [STAGE_W-1:0]             issue_lat;
    logic                           issue_ready;
    logic [SLOT_W-1:0]              issue_slot;
    logic                           bubble;
    logic [STAGE_W-1:0]             bubble_pri;
    logic                           flush;
    logic [STAGE_W-1:0]             flush_pri;
    logic                           wb_ack;
    logic [NUM_SLOTS*DATA_W-1:0]    wb_data_in;
    logic [NUM_SLOTS-1:0]           slot_busy;
    logic [NUM_SLOTS*STAGE_W-1:0]   slot_stage;
    logic [NUM_SLOTS-1:0]           flush_kill;
    logic                           retire_valid;
    logic [SLOT_W-1:0]              retire_slot;
    logic [DATA_W-1:0]              retire_data;

    modport master (
        output issue_valid, issue_lat, bubble, bubble_pri, flush, flush_pri,
               wb_ack, wb_data_in,
        input  issue_ready, issue_slot, slot_busy, slot_stage, flush_kill,
               retire_valid, retire_slot, retire_data
    );

    modport slave (
        input  issue_valid, issue_lat, bubble, bubble_pri, flush, flush_pri,
               wb_ack, wb_data_in,
        output issue_ready, issue_slot, slot_busy, slot_stage, flush_kill,
               retire_valid, retire_slot, retire_data
    );
endinterface

// File: rtl/pipe_slot_sched.sv
// pipe_slot_sched: multi-slot in-flight instruction scheduler.
// Each slot walks IDLE -> RUN (stage 1..lat) -> DONE -> IDLE; completed
// instructions retire strictly in issue order through an order queue.
// Optional feature macro: PIPE_RETIRE_BYPASS_EN lets a head slot finishing its
// last stage retire in the same cycle, skipping DONE.
module pipe_slot_sched #(
    parameter int NUM_SLOTS = 3,
    parameter int STAGE_W   = 3,
    parameter int DATA_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_slot_sched_if.slave bus
);
    localparam int SLOT_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } slot_state_e;

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_d [NUM_SLOTS];
    logic [STAGE_W-1:0]   stage_q [NUM_SLOTS];
    logic [STAGE_W-1:0]   stage_d [NUM_SLOTS];
    logic [STAGE_W-1:0]   lat_q   [NUM_SLOTS];
    logic [STAGE_W-1:0]   lat_d   [NUM_SLOTS];
    logic [DATA_W-1:0]    data_q  [NUM_SLOTS];
    logic [DATA_W-1:0]    data_d  [NUM_SLOTS];
    logic [SLOT_W-1:0]    order_q [NUM_SLOTS];
    logic [SLOT_W-1:0]    order_d [NUM_SLOTS];
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [NUM_SLOTS-1:0] flush_kill_q;
    logic [NUM_SLOTS-1:0] flush_kill_d;

    logic [DATA_W-1:0]    wb_slice [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] free;
    logic [NUM_SLOTS-1:0] held;
    logic [NUM_SLOTS-1:0] kill;
    logic [SLOT_W-1:0]    free_slot;
    logic [SLOT_W-1:0]    head;
    logic                 head_valid;
    logic                 retire_fire;
    logic                 issue_ok;
    logic                 issue_fire;
    logic [STAGE_W-1:0]   issue_lat_eff;

    // Per-slot classification: free, held by bubble, killed by flush (RUN only).
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            wb_slice[i] = bus.wb_data_in[i*DATA_W +: DATA_W];
            free[i]     = (state_q[i] == ST_IDLE);
            held[i]     = (state_q[i] == ST_RUN) && bus.bubble
                          && (stage_q[i] <= bus.bubble_pri);
            kill[i]     = (state_q[i] == ST_RUN) && bus.flush
                          && (stage_q[i] < bus.flush_pri);
        end
    end

    // Lowest-index free slot is the issue target.
    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free[i]) free_slot = SLOT_W'(i);
        end
    end

    // Issue acceptance: an unissued instruction counts as stage 0, so any
    // bubble or any non-zero flush priority blocks it.
    always_comb begin
        issue_ok      = !rst && (|free) && !bus.bubble
                        && !(bus.flush && (bus.flush_pri != '0));
        issue_fire    = issue_ok && bus.issue_valid;
        issue_lat_eff = (bus.issue_lat == '0) ? STAGE_W'(1) : bus.issue_lat;
    end

    // In-order retire from the queue head; never during reset.
    always_comb begin
        head        = order_q[0];
        head_valid  = (count_q != '0);
        retire_fire = 1'b0;
        if (!rst && bus.wb_ack && head_valid) begin
            if (state_q[head] == ST_DONE) begin
                retire_fire = 1'b1;
            end
`ifdef PIPE_RETIRE_BYPASS_EN
            else if ((state_q[head] == ST_RUN) && (stage_q[head] == lat_q[head])
                     && !held[head] && !kill[head]) begin
                retire_fire = 1'b1;
            end
`endif
        end
    end

    // Per-slot next state: flush beats bubble, DONE ignores both.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            state_d[i] = state_q[i];
            stage_d[i] = stage_q[i];
            lat_d[i]   = lat_q[i];
            data_d[i]  = data_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (issue_fire && (free_slot == SLOT_W'(i))) begin
                        state_d[i] = ST_RUN;
                        stage_d[i] = STAGE_W'(1);
                        lat_d[i]   = issue_lat_eff;
                    end
                end
                ST_RUN: begin
                    if (kill[i]) begin
                        state_d[i] = ST_IDLE;
                        stage_d[i] = '0;
                    end else if (!held[i]) begin
                        if (stage_q[i] < lat_q[i]) begin
                            stage_d[i] = stage_q[i] + 1'b1;
                        end else if (retire_fire && (head == SLOT_W'(i))) begin
                            // Bypass retire: result leaves straight from the bus.
                            state_d[i] = ST_IDLE;
                            stage_d[i] = '0;
                        end else begin
                            state_d[i] = ST_DONE;
                            data_d[i]  = wb_slice[i];
                        end
                    end
                end
                ST_DONE: begin
                    if (retire_fire && (head == SLOT_W'(i))) begin
                        state_d[i] = ST_IDLE;
                        stage_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    stage_d[i] = '0;
                end
            endcase
        end
        flush_kill_d = kill;
    end

    // Order queue: drop the retired head and any killed entries, compact,
    // then append the newly issued slot at the tail.
    always_comb begin
        int wr;
        wr = 0;
        for (int p = 0; p < NUM_SLOTS; p++) order_d[p] = order_q[p];
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((k < int'(count_q)) && !((k == 0) && retire_fire) && !kill[order_q[k]]) begin
                for (int p = 0; p < NUM_SLOTS; p++) begin
                    if (p == wr) order_d[p] = order_q[k];
                end
                wr = wr + 1;
            end
        end
        if (issue_fire) begin
            for (int p = 0; p < NUM_SLOTS; p++) begin
                if (p == wr) order_d[p] = free_slot;
            end
            wr = wr + 1;
        end
        count_d = CNT_W'(wr);
    end

    // Output drive: status straight from state flops, retire info from the head.
    always_comb begin
        bus.issue_ready  = issue_ok;
        bus.issue_slot   = free_slot;
        bus.slot_busy    = ~free;
        bus.slot_stage   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            bus.slot_stage[i*STAGE_W +: STAGE_W] = stage_q[i];
        end
        bus.flush_kill   = flush_kill_q;
        bus.retire_valid = retire_fire;
        bus.retire_slot  = retire_fire ? head : '0;
        bus.retire_data  = '0;
        if (retire_fire) begin
            bus.retire_data = (state_q[head] == ST_DONE) ? data_q[head] : wb_slice[head];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: captured data is cleared on reset because it is observable state, not scratch storage.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                // NOTE: sequential state uses <= so every flop samples pre-edge values.
                state_q[i] <= ST_IDLE;
                stage_q[i] <= '0;
                lat_q[i]   <= '0;
                data_q[i]  <= '0;
                order_q[i] <= '0;
            end
            count_q      <= '0;
            flush_kill_q <= '0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            lat_q        <= lat_d;
            data_q       <= data_d;
            order_q      <= order_d;
            count_q      <= count_d;
            flush_kill_q <= flush_kill_d;
        end
    end
endmodule

// File: tb/tb_pipe_slot_sched.sv
// Self-checking bench for pipe_slot_sched: hand-written corner sequences plus a
// table of single-issue latency vectors; retires are checked by a scoreboard.
module tb_pipe_slot_sched;
    localparam int N  = 3;
    localparam int SW = 3;
    localparam int DW = 32;
`ifdef PIPE_RETIRE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk;
    logic rst;
    logic [DW-1:0] wb_val [N];

    pipe_slot_sched_if #(.NUM_SLOTS(N), .STAGE_W(SW), .DATA_W(DW)) bus ();

    pipe_slot_sched #(.NUM_SLOTS(N), .STAGE_W(SW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.wb_data_in = {wb_val[2], wb_val[1], wb_val[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [2:0]  lat;
        logic [31:0] data;
        int          exp_cycles;
    } vec_t;
    vec_t vecs[5];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   bus.slot_busy, 0);
        check({tag, "_stage"},  bus.slot_stage, 0);
        check({tag, "_kill"},   bus.flush_kill, 0);
        check({tag, "_rv"},     bus.retire_valid, 0);
        check({tag, "_rslot"},  bus.retire_slot, 0);
        check({tag, "_rdata"},  bus.retire_data, 0);
        check({tag, "_islot"},  bus.issue_slot, 0);
    endtask

    // Present one instruction for one cycle; expected slot comes from the caller.
    task automatic do_issue(input logic [2:0] lat, input int exp_slot, input logic [31:0] data);
        sb_t e;
        bus.issue_valid = 1'b1;
        bus.issue_lat   = lat;
        wb_val[exp_slot] = data;
        #1;
        check("issue_ready", bus.issue_ready, 1);
        check("issue_slot", bus.issue_slot, exp_slot);
        if (bus.issue_ready) begin
            e.slot = exp_slot;
            e.data = data;
            sb.push_back(e);
        end
        tick();
        bus.issue_valid = 1'b0;
    endtask

    task automatic sb_drop(input int s);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].slot == s) begin
                sb.delete(i);
                break;
            end
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if ((sb.size() == 0) && (bus.slot_busy == '0)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, ok, 1);
        tick();
    endtask

    // Scoreboard: every retire must match the oldest outstanding issue.
    always @(negedge clk) begin
        sb_t e;
        #2;
        if (bus.retire_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_retire: slot %0d with empty scoreboard", bus.retire_slot);
            end else begin
                e = sb.pop_front();
                check("sb_retire_slot", bus.retire_slot, e.slot);
                check("sb_retire_data", bus.retire_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst             = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_lat   = '0;
        bus.bubble      = 1'b0;
        bus.bubble_pri  = '0;
        bus.flush       = 1'b0;
        bus.flush_pri   = '0;
        bus.wb_ack      = 1'b0;
        for (int i = 0; i < N; i++) wb_val[i] = '0;

        // Reset state.
        tick();
        tick();
        #1;
        check_reset_outputs("rst_hold");
        check("rst_issue_ready", bus.issue_ready, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_rel");
        check("rst_rel_ready", bus.issue_ready, 1);
        tick();

        // Single issue lat=3: stages 1..3, retire at cycle 4 (3 with bypass).
        bus.wb_ack = 1'b1;
        do_issue(3'd3, 0, 32'h0000_1234);
        for (int n = 1; n <= 4; n++) begin
            #1;
            if (n <= 3) check("a_stage", bus.slot_stage[2:0], n);
            check("a_retire_valid", bus.retire_valid, (n == 4 - BYP));
            tick();
        end
        wait_empty("a_drain", 10);

        // Out-of-order completion, in-order retire.
        do_issue(3'd4, 0, 32'hAAAA_0000);
        do_issue(3'd1, 1, 32'hBBBB_0001);
        tick();
        #1;
        check("b_busy", bus.slot_busy, 3'b011);
        check("b_no_early_retire", bus.retire_valid, 0);
        tick();
        wait_empty("b_drain", 20);

        // Fill all slots, then free one.
        bus.wb_ack = 1'b0;
        do_issue(3'd2, 0, 32'hC000_0000);
        do_issue(3'd2, 1, 32'hC000_0001);
        do_issue(3'd2, 2, 32'hC000_0002);
        #1;
        check("c_full_ready", bus.issue_ready, 0);
        tick();
        tick();
        tick();
        bus.wb_ack = 1'b1;
        #1;
        check("c_retire_valid", bus.retire_valid, 1);
        tick();
        bus.wb_ack = 1'b0;
        #1;
        check("c_ready_after", bus.issue_ready, 1);
        check("c_slot_after", bus.issue_slot, 0);
        bus.wb_ack = 1'b1;
        tick();
        wait_empty("c_drain", 20);

        // Bubble: stage-1 slot holds, stage-3 slot advances.
        do_issue(3'd7, 0, 32'hD000_0000);
        tick();
        do_issue(3'd7, 1, 32'hD000_0001);
        bus.bubble     = 1'b1;
        bus.bubble_pri = 3'd1;
        #1;
        check("d_pre_stage0", bus.slot_stage[2:0], 3);
        check("d_pre_stage1", bus.slot_stage[5:3], 1);
        check("d_ready", bus.issue_ready, 0);
        tick();
        bus.bubble = 1'b0;
        #1;
        check("d_stage0", bus.slot_stage[2:0], 4);
        check("d_stage1", bus.slot_stage[5:3], 1);
        tick();
        wait_empty("d_drain", 30);

        // Flush: stages 3,2,1 with flush_pri=3 kills the two youngest.
        do_issue(3'd7, 0, 32'hE000_0000);
        do_issue(3'd7, 1, 32'hE000_0001);
        do_issue(3'd7, 2, 32'hE000_0002);
        bus.flush     = 1'b1;
        bus.flush_pri = 3'd3;
        #1;
        check("e_ready", bus.issue_ready, 0);
        sb_drop(1);
        sb_drop(2);
        tick();
        bus.flush = 1'b0;
        #1;
        check("e_kill", bus.flush_kill, 3'b110);
        check("e_busy", bus.slot_busy, 3'b001);
        check("e_stage0", bus.slot_stage[2:0], 4);
        tick();
        #1;
        check("e_kill_clear", bus.flush_kill, 0);
        tick();
        wait_empty("e_drain", 30);

        // Reset mid-operation: two RUN, one DONE, wb_ack high.
        bus.wb_ack = 1'b0;
        do_issue(3'd1, 0, 32'hF000_0000);
        do_issue(3'd7, 1, 32'hF000_0001);
        do_issue(3'd7, 2, 32'hF000_0002);
        rst        = 1'b1;
        bus.wb_ack = 1'b1;
        #1;
        check("f_busy_before", bus.slot_busy, 3'b111);
        check("f_no_retire", bus.retire_valid, 0);
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("f_after");
        check("f_ready", bus.issue_ready, 1);
        tick();

        // Table-driven single-issue latencies (lat 0 behaves as 1).
        vecs[0] = '{3'd0, 32'h0000_00A0, 2};
        vecs[1] = '{3'd1, 32'h0000_00A1, 2};
        vecs[2] = '{3'd2, 32'h1357_9BDF, 3};
        vecs[3] = '{3'd5, 32'hFFFF_FFFF, 6};
        vecs[4] = '{3'd7, 32'h8000_0001, 8};
        bus.wb_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_issue(vecs[i].lat, 0, vecs[i].data);
            seen = 0;
            for (int c = 1; c <= 12; c++) begin
                #1;
                if (c == 1) check("tbl_stage1", bus.slot_stage[2:0], 1);
                if (bus.retire_valid) begin
                    seen = c;
                    break;
                end
                tick();
            end
            check("tbl_latency", seen, vecs[i].exp_cycles - BYP);
            tick();
            wait_empty("tbl_drain", 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
